pipeline_stage_reg: RTL and testbench
=====================================

# pipeline_stage_reg

Parametrised inter-stage pipeline register for the pipelined MIPS datapath, carrying the decoded fields: opcode, source/destination register, immediate, jump address and signed data. It adds what a plain clocked register lacks: a valid/ready handshake, a one-entry skid buffer so back-pressure never drops an instruction, and a synchronous flush that inserts a bubble. It is instantiated between any two stages, e.g. IF/ID or ID/EX.

## Interface
Parameters:
- OPC_W, 2, opcode width
- REG_W, 3, register-specifier width
- IMM_W, 3, immediate width
- ADDR_W, 8, jump-address width
- DATA_W, 8, signed data width
- NOP_OPC, 0, opcode value driven on reset/flush (bubble marker)

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high; dominates all other inputs
- flush  input  1  synchronous kill of all held and incoming instructions
- in_valid  input  1  upstream presents a valid instruction
- in_ready  output  1  stage can accept; equals NOT skid_valid (no comb path from out_ready)
- opcode  input  OPC_W  incoming opcode
- rSrc  input  REG_W  incoming source register
- rDest  input  REG_W  incoming destination register
- immediate_data  input  IMM_W  incoming immediate
- jump_address  input  ADDR_W  incoming jump address
- data  input signed  DATA_W  incoming data
- out_valid  output  1  output fields hold a valid instruction
- out_ready  input  1  downstream consumes when out_valid and out_ready
- opc, reg_src, reg_dest, im_da, pja  output  widths as matching inputs  registered fields
- reg_data  output signed  DATA_W  registered data

## Operation
- Two storage slots: main (drives outputs) and skid (hidden), each a full field bundle plus valid bit.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Priority per cycle: reset > flush > normal.
- Normal update:
  - main empty or drain, skid_valid=1: main <- skid; skid_valid <- 0.
  - main empty or drain, skid empty, accept: main <- input; out_valid <- 1.
  - main empty or drain, nothing available: out_valid <- 0; fields hold.
  - out_valid & !out_ready & accept: skid <- input; skid_valid <- 1; main holds.
  - Case skid_valid & accept cannot occur, since in_ready=0 while skid is full.
- Order is preserved: skid contents always leave before any newer input.
- Flush: out_valid <- 0, skid_valid <- 0, opc <- NOP_OPC; the other output fields hold. An input accepted in the flush cycle is discarded.
- Reset: out_valid=0, skid_valid=0 (so in_ready=1 from the next cycle), opc=NOP_OPC, reg_src=reg_dest=0, im_da=0, pja=0, reg_data=0. An accept during the reset cycle is discarded.
- Data passes through unmodified; no sign extension or width conversion.

## Timing
- Latency: 1 cycle input-to-output when unstalled (accept at edge N gives out_valid/fields valid after edge N).
- Throughput: 1 instruction/cycle sustained with out_ready held high.
- Output fields change only at posedge and are stable while out_valid & !out_ready.
- in_ready falls 1 cycle after the first stalled accept (skid fills) and rises the cycle after skid drains to main.
- Maximum occupancy is 2 instructions; full is skid_valid=1, empty is out_valid=0.
- Flush takes effect at the edge where it is sampled; out_valid=0 and in_ready=1 in the following cycle.
- Simultaneous flush & drain: downstream sees the transfer in that cycle; the state is then cleared.
- Reset asserted mid-stall with both slots full: both slots are emptied at that edge and no instruction reappears.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, opcode=2'b11 -> out_valid=0, opc=NOP_OPC, all other outputs 0, in_ready=1 after release.
- Streaming: out_ready=1, send data = -5, 3, 127 on consecutive cycles -> reg_data = -5, 3, 127 one cycle later each; out_valid high for 3 cycles.
- Back-pressure: out_ready=0 while sending A (rDest=3'd2) then B (rDest=3'd5) -> out shows A, in_ready=0 next cycle; raise out_ready -> A, then B, then out_valid=0, with no loss or duplication.
- Flush with full skid: A in main, B in skid, assert flush for 1 cycle -> out_valid=0, opc=NOP_OPC, in_ready=1 next cycle; neither A nor B ever appears later.
- Flush plus accept: in_valid=1 with jump_address=8'hA5 in the flush cycle -> pja never shows 8'hA5 with out_valid=1.
- Random: random in_valid/out_ready/flush over 10k cycles against a scoreboard queue model -> the output sequence matches in order, and occupancy never exceeds 2.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: valid/ready inter-stage register with one-entry skid buffer and flush
// Ports: clk/reset (sync, active-high), flush kills held and incoming instructions,
// in_valid/in_ready + decoded input fields upstream, out_valid/out_ready + registered fields downstream.
module pipeline_stage_reg #(
  parameter int OPC_W   = 2,
  parameter int REG_W   = 3,
  parameter int IMM_W   = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NOP_OPC = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPC_W-1:0]         opcode,
  input  logic [REG_W-1:0]         rSrc,
  input  logic [REG_W-1:0]         rDest,
  input  logic [IMM_W-1:0]         immediate_data,
  input  logic [ADDR_W-1:0]        jump_address,
  input  logic signed [DATA_W-1:0] data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPC_W-1:0]         opc,
  output logic [REG_W-1:0]         reg_src,
  output logic [REG_W-1:0]         reg_dest,
  output logic [IMM_W-1:0]         im_da,
  output logic [ADDR_W-1:0]        pja,
  output logic signed [DATA_W-1:0] reg_data
);
  localparam int BW = OPC_W + 2*REG_W + IMM_W + ADDR_W + DATA_W;
  logic [BW-1:0] r_main, r_skid, w_in;
  logic r_out_valid, r_skid_valid, w_accept, w_load;
  assign w_in = {opcode, rSrc, rDest, immediate_data, jump_address, data};
  assign {opc, reg_src, reg_dest, im_da, pja, reg_data} = r_main;
  assign out_valid = r_out_valid;
  // in_ready depends only on state, so there is no combinational path from out_ready
  assign in_ready = !r_skid_valid;
  assign w_accept = in_valid & in_ready;
  assign w_load = !r_out_valid | out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= {OPC_W'(NOP_OPC), {(BW-OPC_W){1'b0}}};
    end else if (flush) begin
      r_out_valid             <= 1'b0;
      r_skid_valid            <= 1'b0;
      r_main[BW-1 -: OPC_W]   <= OPC_W'(NOP_OPC);
    end else if (w_load) begin
      // skid holds the older instruction, so it always refills main first
      r_out_valid  <= r_skid_valid | w_accept;
      r_skid_valid <= 1'b0;
      if (r_skid_valid) r_main <= r_skid;
      else if (w_accept) r_main <= w_in;
    end else if (w_accept) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: vector table, corner sequences and scoreboard for pipeline_stage_reg
module tb_pipeline_stage_reg;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [1:0] opcode = 0, opc;
  logic [2:0] rSrc = 0, rDest = 0, immediate_data = 0, reg_src, reg_dest, im_da;
  logic [7:0] jump_address = 0, pja;
  logic signed [7:0] data = 0, reg_data;
  int passes = 0, total = 0;
  bit armed = 0;
  logic [26:0] q[$];
  logic [26:0] in_b, out_b;

  pipeline_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rSrc(rSrc), .rDest(rDest), .immediate_data(immediate_data),
    .jump_address(jump_address), .data(data), .out_valid(out_valid), .out_ready(out_ready),
    .opc(opc), .reg_src(reg_src), .reg_dest(reg_dest), .im_da(im_da), .pja(pja), .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  assign in_b  = {opcode, rSrc, rDest, immediate_data, jump_address, data};
  assign out_b = {opc, reg_src, reg_dest, im_da, pja, reg_data};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard: outputs reflect state after the last edge, inputs are those about to be sampled
  always @(negedge clk) begin
    if (armed) begin
      chk("occ_out_valid", out_valid, q.size() > 0);
      chk("occ_in_ready", in_ready, q.size() < 2);
      if (out_valid && q.size() > 0) chk("sb_item", out_b, q[0]);
    end
    if (reset) begin
      q.delete();
      armed = 1;
    end else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(in_b);
    end
  end

  typedef struct {
    logic iv, ordy, fl;
    logic signed [7:0] d;
    logic [2:0] rdst;
    logic [7:0] ja;
    logic ev, er;
    logic [1:0] eopc;
    logic signed [7:0] ed;
    logic [2:0] erd;
  } vec_t;
  vec_t v[$];

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic signed [7:0] d,
                       input logic [2:0] rdst, input logic [7:0] ja);
    in_valid = iv; out_ready = ordy; flush = fl; data = d; rDest = rdst; jump_address = ja;
    opcode = 2'd1; rSrc = 3'd6; immediate_data = 3'd3;
  endtask

  initial begin
    v.push_back('{1,1,0,-5,0,0,     1,1,1,-5,0});
    v.push_back('{1,1,0,3,0,0,      1,1,1,3,0});
    v.push_back('{1,1,0,127,0,0,    1,1,1,127,0});
    v.push_back('{0,1,0,0,0,0,      0,1,1,0,0});
    v.push_back('{1,0,0,10,2,0,     1,1,1,10,2});
    v.push_back('{1,0,0,20,5,0,     1,0,1,10,2});
    v.push_back('{1,0,0,99,7,0,     1,0,1,10,2});
    v.push_back('{0,1,0,0,0,0,      1,1,1,20,5});
    v.push_back('{0,1,0,0,0,0,      0,1,1,0,0});
    v.push_back('{1,0,0,30,1,0,     1,1,1,30,1});
    v.push_back('{1,0,0,40,3,0,     1,0,1,30,1});
    v.push_back('{0,0,1,0,0,0,      0,1,0,0,0});
    v.push_back('{0,1,0,0,0,0,      0,1,0,0,0});
    v.push_back('{1,1,1,55,4,8'hA5, 0,1,0,0,0});
    v.push_back('{0,1,0,0,0,0,      0,1,0,0,0});
    v.push_back('{1,1,0,60,6,8'h11, 1,1,1,60,6});
    v.push_back('{0,1,1,0,0,0,      0,1,0,0,0});

    reset = 1; in_valid = 1; opcode = 2'b11; data = -1; rSrc = 7; rDest = 7;
    immediate_data = 7; jump_address = 8'hFF;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_opc", opc, 0);
      chk("rst_fields", {reg_src, reg_dest, im_da, pja, reg_data}, 0);
    end
    reset = 0; in_valid = 0;
    #1 chk("rst_in_ready", in_ready, 1);

    foreach (v[i]) begin
      drive(v[i].iv, v[i].ordy, v[i].fl, v[i].d, v[i].rdst, v[i].ja);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, v[i].ev);
      chk($sformatf("vec%0d_in_ready", i), in_ready, v[i].er);
      chk($sformatf("vec%0d_opc", i), opc, v[i].eopc);
      if (v[i].ev) begin
        chk($sformatf("vec%0d_reg_data", i), reg_data, v[i].ed);
        chk($sformatf("vec%0d_reg_dest", i), reg_dest, v[i].erd);
      end
    end

    drive(1, 0, 0, 70, 1, 0); @(posedge clk); #1;
    drive(1, 0, 0, 80, 2, 0); @(posedge clk); #1;
    chk("stall_full", in_ready, 0);
    drive(0, 0, 0, 0, 0, 0); reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    drive(0, 1, 0, 0, 0, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_reappear", out_valid, 0);
    end

    for (int n = 0; n < 10000; n++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      opcode = 2'($urandom); rSrc = 3'($urandom); rDest = 3'($urandom);
      immediate_data = 3'($urandom); jump_address = 8'($urandom); data = 8'($urandom);
      @(posedge clk); #1;
    end
    drive(0, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
